spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: none; word width is fixed at 10 bits in and 8 bits out.
REQ-002 clk  input  1  single clock, which is the SPI serial clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 SS_n  input  1  slave select, active-low; high aborts or ends a frame.
REQ-005 MOSI  input  1  serial data from the master, MSB first.
REQ-006 MISO  output  1  serial read data to the master, MSB first; 0 when not transmitting.
REQ-007 rx_data  output  10  assembled command word to the RAM; bits [9:8] are the opcode, bits [7:0] are the payload.
REQ-008 rx_valid  output  1  one-cycle strobe marking rx_data valid.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  RAM read data valid; sampled only while the slave is waiting for read data.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n sampled low SHALL move the FSM to CHK_CMD; otherwise it stays in IDLE.
REQ-013 CHK_CMD: the edge SHALL capture MOSI as word bit 9.
REQ-014 CHK_CMD transitions SHALL be:
- MOSI=0 -> WRITE;
- MOSI=1 with rd_pending=0 -> READ_ADD;
- MOSI=1 with rd_pending=1 -> READ_DATA.
REQ-015 WRITE, READ_ADD and READ_DATA SHALL each shift in the remaining 9 bits (bits 8..0) MSB first, one per edge, counted by a 4-bit bit counter.
REQ-016 On the edge sampling bit 0:
- rx_data SHALL load the full 10-bit word;
- rx_valid SHALL be 1 for exactly the following cycle.
REQ-017 rx_data SHALL hold its value until the next completed word.
REQ-018 The slave SHALL forward words unmodified; opcode interpretation belongs to the RAM.
REQ-019 rd_pending SHALL set when a READ_ADD word completes and clear when a READ_DATA word completes.
REQ-020 After a WRITE or READ_ADD word completes, the FSM SHALL stay in its state with MISO=0, ignoring MOSI, until SS_n goes high.
REQ-021 After a READ_DATA word completes, the slave SHALL wait for tx_valid.
- The first edge with tx_valid=1 loads tx_data into an 8-bit shift register and drives MISO=tx_data[7].
- The next 7 edges drive bits 6..0.
- MISO then returns to 0.
REQ-022 Exactly 8 MISO bits SHALL be sent per read; tx_valid pulses during or after transmission are ignored.
REQ-023 If tx_valid never arrives, the slave SHALL wait with MISO=0 until SS_n goes high.
REQ-024 SS_n high sampled in any non-IDLE state SHALL:
- return the FSM to IDLE on that edge;
- clear the bit counter and MISO;
- discard the partial word with no rx_valid;
- leave rd_pending unchanged.
REQ-025 SS_n high on the same edge as the final bit SHALL win: no rx_valid is issued and rd_pending is not updated.
REQ-026 Frames SHALL be back-to-back capable: SS_n high for one edge followed by low SHALL start a new frame normally.

Reset
REQ-027 rst=1 on a rising edge SHALL force the FSM to IDLE and zero the following: rx_data, rx_valid, MISO, rd_pending, the bit counter and the tx shift register.
REQ-028 Reset SHALL take priority over SS_n and tx_valid.
REQ-029 A reset mid-frame SHALL discard the frame with no rx_valid.

Verification
REQ-030 Write address: SS_n low, MOSI stream 00_0000_0101 -> rx_data=0x005 and a single rx_valid pulse; SS_n high -> IDLE.
REQ-031 Write data: stream 01_1010_1010 -> rx_data=0x1AA and one rx_valid; MISO remains 0 throughout.
REQ-032 Read address then read data:
- frame 1, stream 10_0000_0101 -> rx_data=0x205 and rd_pending=1;
- frame 2, stream 11_0000_0000 -> rx_data=0x300;
- RAM returns tx_valid with tx_data=0xC3 -> MISO=1,1,0,0,0,0,1,1 on consecutive edges, then 0;
- rd_pending=0 afterwards.
REQ-033 Abort: SS_n raised after 5 bits of a WRITE frame -> no rx_valid, FSM in IDLE next cycle; the following full frame 00_1111_1111 -> rx_data=0x0FF.
REQ-034 Reset mid-read: rst asserted while MISO is shifting 0xC3 -> MISO=0, rd_pending=0 and FSM in IDLE on the next cycle.
REQ-035 Pending routing: two consecutive frames starting with MOSI=1 without reset -> the first is routed to READ_ADD and the second to READ_DATA; a third such frame is routed to READ_ADD.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: deserialises 10-bit command words
// from MOSI and serialises 8-bit read data onto MISO.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt;
    logic [8:0]  rx_shift;
    logic        rd_pending;
    logic [6:0]  tx_shift;
    logic [2:0]  tx_cnt;
    logic        tx_busy;
    logic        tx_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!SS_n) state_nxt = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)            state_nxt = IDLE;
                else if (!MOSI)      state_nxt = WRITE;
                else if (rd_pending) state_nxt = READ_DATA;
                else                 state_nxt = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // bit_cnt counts shifted bits 8..0; reaching 9 marks the word as complete
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_pending <= 1'b0;
            MISO       <= 1'b0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE || SS_n) begin
                bit_cnt <= '0;
                MISO    <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        rx_shift <= {8'b0, MOSI};
                        bit_cnt  <= '0;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt < 4'd9) begin
                            rx_shift <= {rx_shift[7:0], MOSI};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                rx_data  <= {rx_shift, MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD)  rd_pending <= 1'b1;
                                if (state == READ_DATA) rd_pending <= 1'b0;
                            end
                        end else if (state == READ_DATA) begin
                            if (tx_busy) begin
                                if (tx_cnt == 3'd7) begin
                                    MISO    <= 1'b0;
                                    tx_busy <= 1'b0;
                                    tx_done <= 1'b1;
                                end else begin
                                    MISO     <= tx_shift[6];
                                    tx_shift <= {tx_shift[5:0], 1'b0};
                                    tx_cnt   <= tx_cnt + 3'd1;
                                end
                            end else if (!tx_done && tx_valid) begin
                                MISO     <= tx_data[7];
                                tx_shift <= tx_data[6:0];
                                tx_cnt   <= '0;
                                tx_busy  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: write, read, abort, reset and
// pending-read routing scenarios with hand-computed expectations.
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    logic miso_or = 1'b0;

    spi_slave dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid) pulses++;
        miso_or = miso_or | MISO;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends nbits of w MSB first; when nbits < 10 the next bit's edge has SS_n high.
    task automatic frame(input logic [9:0] w, input int nbits);
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[9-i];
            tick();
        end
        if (nbits < 10) begin
            MOSI = w[9-nbits];
            SS_n = 1'b1;
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    logic [7:0] exp_bits;

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_miso",     16'(MISO), 16'h0);
        chk("reset_rx_valid", 16'(rx_valid), 16'h0);
        chk("reset_rx_data",  16'(rx_data), 16'h000);
        chk("reset_pending",  16'(dut.rd_pending), 16'h0);
        chk("reset_state",    16'(dut.state), 16'd0);

        // write address
        pulses = 0; miso_or = 1'b0;
        frame(10'h005, 10);
        chk("wa_rx_valid", 16'(rx_valid), 16'h1);
        chk("wa_rx_data",  16'(rx_data), 16'h005);
        MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tick();
        tx_valid = 1'b0;
        chk("wa_pulses",   16'(pulses), 16'd1);
        chk("wa_hold_state", 16'(dut.state), 16'd2);
        end_frame();
        chk("wa_idle", 16'(dut.state), 16'd0);

        // write data
        pulses = 0;
        frame(10'h1AA, 10);
        chk("wd_rx_data", 16'(rx_data), 16'h1AA);
        tick();
        chk("wd_pulses",  16'(pulses), 16'd1);
        chk("wd_miso_quiet", 16'(miso_or), 16'h0);
        end_frame();

        // read address
        frame(10'h205, 10);
        chk("ra_rx_data", 16'(rx_data), 16'h205);
        chk("ra_pending", 16'(dut.rd_pending), 16'h1);
        chk("ra_state",   16'(dut.state), 16'd3);
        end_frame();

        // read data
        frame(10'h300, 10);
        chk("rd_rx_data", 16'(rx_data), 16'h300);
        chk("rd_state",   16'(dut.state), 16'd4);
        chk("rd_pending_clr", 16'(dut.rd_pending), 16'h0);
        tick(); tick();
        chk("rd_wait_miso", 16'(MISO), 16'h0);
        tx_data = 8'hC3; tx_valid = 1'b1;
        exp_bits = 8'hC3;
        tick();
        tx_valid = 1'b0;
        chk("rd_miso_b7", 16'(MISO), 16'(exp_bits[7]));
        for (int b = 6; b >= 0; b--) begin
            if (b == 3) tx_valid = 1'b1;
            tick();
            chk($sformatf("rd_miso_b%0d", b), 16'(MISO), 16'(exp_bits[b]));
        end
        tx_valid = 1'b0;
        tick();
        chk("rd_miso_after", 16'(MISO), 16'h0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tick();
        tx_valid = 1'b0;
        chk("rd_extra_tx_ignored", 16'(MISO), 16'h0);
        end_frame();

        // abort after 5 bits of a write frame
        pulses = 0;
        frame(10'h0FF, 5);
        chk("ab_state",    16'(dut.state), 16'd0);
        chk("ab_no_valid", 16'(pulses), 16'd0);
        chk("ab_rx_hold",  16'(rx_data), 16'h300);
        frame(10'h0FF, 10);
        chk("ab_next_frame", 16'(rx_data), 16'h0FF);
        end_frame();

        // SS_n rises on the final bit's edge of a read-address frame
        pulses = 0;
        frame(10'h2AA, 9);
        tick();
        chk("fb_no_valid", 16'(pulses), 16'd0);
        chk("fb_pending",  16'(dut.rd_pending), 16'h0);
        chk("fb_rx_hold",  16'(rx_data), 16'h0FF);

        // pending routing across three read-type frames
        frame(10'h3FF, 10);
        chk("pr1_state", 16'(dut.state), 16'd3);
        chk("pr1_pending", 16'(dut.rd_pending), 16'h1);
        end_frame();
        frame(10'h3FF, 10);
        chk("pr2_state", 16'(dut.state), 16'd4);
        chk("pr2_pending", 16'(dut.rd_pending), 16'h0);
        end_frame();
        frame(10'h3FF, 10);
        chk("pr3_state", 16'(dut.state), 16'd3);
        end_frame();

        // reset while MISO is shifting
        frame(10'h300, 10);
        chk("rr_state", 16'(dut.state), 16'd4);
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("rr_miso_b7", 16'(MISO), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_miso",    16'(MISO), 16'h0);
        chk("rr_pending", 16'(dut.rd_pending), 16'h0);
        chk("rr_state_idle", 16'(dut.state), 16'd0);
        chk("rr_rx_data", 16'(rx_data), 16'h000);

        // reset mid-frame with SS_n held low: no word, reset wins
        pulses = 0;
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0; tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        SS_n = 1'b1;
        tick(); tick();
        chk("rm_no_valid", 16'(pulses), 16'd0);
        chk("rm_state",    16'(dut.state), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
